// File: rtl/vx_context_seq.sv
// Per-warp register context: NT lanes x NR registers, two combinational read
// ports with JAL/forwarding bypass, a clone sequencer that copies lane 0 into a
// target lane one register per cycle, and a delayed wspawn bulk load of lane 0.
module vx_context_seq #(
  parameter int unsigned NT         = 4,
  parameter int unsigned NR         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned WSPAWN_DLY = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_wb_warp,
  input  logic [NT-1:0]          in_valid,
  input  logic                   in_write_register,
  input  logic [$clog2(NR)-1:0]  in_rd,
  input  logic [NT*DW-1:0]       in_write_data,
  input  logic [$clog2(NR)-1:0]  in_src1,
  input  logic [$clog2(NR)-1:0]  in_src2,
  input  logic [DW-1:0]          in_curr_PC,
  input  logic                   in_is_jal,
  input  logic                   in_src1_fwd,
  input  logic                   in_src2_fwd,
  input  logic [NT*DW-1:0]       in_src1_fwd_data,
  input  logic [NT*DW-1:0]       in_src2_fwd_data,
  input  logic                   in_is_clone,
  input  logic                   in_wspawn,
  input  logic [NR*DW-1:0]       in_wspawn_regs,
  output logic [NT*DW-1:0]       out_a_reg_data,
  output logic [NT*DW-1:0]       out_b_reg_data,
  output logic                   out_clone_stall,
  output logic                   out_clone_err,
  output logic                   out_busy
);

  localparam int unsigned RW = $clog2(NR);
  localparam int unsigned LW = (NT > 1) ? $clog2(NT) : 1;

  typedef enum logic [1:0] {StIdle, StClone, StWsWait, StWsLoad} state_e;

  logic [DW-1:0] rf_q [NT][NR];
  state_e        state_q, state_d;
  logic [RW-1:0] k_q, k_d;
  logic [LW-1:0] tgt_q, tgt_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          ws_pend_q, ws_pend_d;

  logic [DW-1:0] tgt_val;
  logic          tgt_ok;

  // Clone target comes from lane 0's src1 register; lane 0 itself is not a legal target.
  assign tgt_val  = rf_q[0][in_src1];
  assign tgt_ok   = (tgt_val != '0) && (tgt_val < DW'(NT));
  assign out_busy = (state_q != StIdle);

  // Next-state, clone/wspawn sequencing and stall/error outputs.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    tgt_d           = tgt_q;
    cnt_d           = cnt_q;
    ws_pend_d       = ws_pend_q;
    out_clone_stall = 1'b0;
    out_clone_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_is_clone) begin
          if (tgt_ok) begin
            tgt_d           = tgt_val[LW-1:0];
            k_d             = RW'(1);
            ws_pend_d       = in_wspawn;
            state_d         = StClone;
            out_clone_stall = 1'b1;
          end else begin
            // Gate on reset so the cleared array cannot fake an error pulse.
            out_clone_err = reset;
          end
        end else if (in_wspawn) begin
          cnt_d           = 6'(WSPAWN_DLY);
          state_d         = StWsWait;
          out_clone_stall = 1'b1;
        end
      end
      StClone: begin
        out_clone_stall = 1'b1;
        k_d             = k_q + RW'(1);
        if (k_q == RW'(NR - 1)) begin
          k_d       = '0;
          ws_pend_d = 1'b0;
          // A wspawn that lost arbitration to this clone starts right away.
          if (ws_pend_q && in_wspawn) begin
            cnt_d   = 6'(WSPAWN_DLY);
            state_d = StWsWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWsWait: begin
        out_clone_stall = 1'b1;
        cnt_d           = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          cnt_d   = '0;
          state_d = StWsLoad;
        end
      end
      StWsLoad: begin
        out_clone_stall = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      ws_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      ws_pend_q <= ws_pend_d;
    end
  end

  // Register array; register 0 is never written. Writeback beats copy/load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NT; i++) begin
        for (int r = 0; r < NR; r++) begin
          rf_q[i][r] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        for (int r = 1; r < NR; r++) begin
          if (in_wb_warp && in_write_register && in_valid[i] && (in_rd == RW'(r))) begin
            rf_q[i][r] <= in_write_data[i*DW +: DW];
          end else if ((state_q == StClone) && (tgt_q == LW'(i)) && (k_q == RW'(r))) begin
            rf_q[i][r] <= rf_q[0][r];
          end else if ((state_q == StWsLoad) && (i == 0)) begin
            rf_q[i][r] <= in_wspawn_regs[r*DW +: DW];
          end
        end
      end
    end
  end

  // Read ports with JAL and forwarding bypass.
  always_comb begin
    out_a_reg_data = '0;
    out_b_reg_data = '0;
    for (int i = 0; i < NT; i++) begin
      if (in_is_jal) begin
        out_a_reg_data[i*DW +: DW] = in_curr_PC;
      end else if (in_src1_fwd) begin
        out_a_reg_data[i*DW +: DW] = in_src1_fwd_data[i*DW +: DW];
      end else begin
        out_a_reg_data[i*DW +: DW] = rf_q[i][in_src1];
      end
      if (in_src2_fwd) begin
        out_b_reg_data[i*DW +: DW] = in_src2_fwd_data[i*DW +: DW];
      end else begin
        out_b_reg_data[i*DW +: DW] = rf_q[i][in_src2];
      end
    end
  end

endmodule

// File: tb/tb_vx_context_seq.sv
// Scoreboard bench for vx_context_seq: stimulus pushes expected read values,
// error pulses and busy/stall run lengths; a negedge monitor pops and compares.
module tb_vx_context_seq;

  localparam int NT = 4;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_wb_warp;
  logic [NT-1:0]     in_valid;
  logic              in_write_register;
  logic [RW-1:0]     in_rd;
  logic [NT*DW-1:0]  in_write_data;
  logic [RW-1:0]     in_src1, in_src2;
  logic [DW-1:0]     in_curr_PC;
  logic              in_is_jal, in_src1_fwd, in_src2_fwd;
  logic [NT*DW-1:0]  in_src1_fwd_data, in_src2_fwd_data;
  logic              in_is_clone, in_wspawn;
  logic [NR*DW-1:0]  in_wspawn_regs;
  logic [NT*DW-1:0]  out_a_reg_data, out_b_reg_data;
  logic              out_clone_stall, out_clone_err, out_busy;

  vx_context_seq #(.NT(NT), .NR(NR), .DW(DW), .WSPAWN_DLY(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_wb_warp        (in_wb_warp),
    .in_valid          (in_valid),
    .in_write_register (in_write_register),
    .in_rd             (in_rd),
    .in_write_data     (in_write_data),
    .in_src1           (in_src1),
    .in_src2           (in_src2),
    .in_curr_PC        (in_curr_PC),
    .in_is_jal         (in_is_jal),
    .in_src1_fwd       (in_src1_fwd),
    .in_src2_fwd       (in_src2_fwd),
    .in_src1_fwd_data  (in_src1_fwd_data),
    .in_src2_fwd_data  (in_src2_fwd_data),
    .in_is_clone       (in_is_clone),
    .in_wspawn         (in_wspawn),
    .in_wspawn_regs    (in_wspawn_regs),
    .out_a_reg_data    (out_a_reg_data),
    .out_b_reg_data    (out_b_reg_data),
    .out_clone_stall   (out_clone_stall),
    .out_clone_err     (out_clone_err),
    .out_busy          (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
  } probe_t;

  probe_t probe_q[$];
  string  name_q[$];
  string  err_q[$];
  int     busy_q[$];
  int     stall_q[$];
  logic   rd_strobe = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     busy_run = 0;
  int     stall_run = 0;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rd_strobe) begin
      checks++;
      if (probe_q.size() == 0) begin
        errors++;
        $display("FAIL probe_underflow: got strobe, want queued expectation");
      end else begin
        probe_t p;
        string  nm;
        p  = probe_q.pop_front();
        nm = name_q.pop_front();
        if (out_a_reg_data[p.lane*DW +: DW] !== p.a) begin
          errors++;
          $display("FAIL %s_a: got %h want %h", nm, out_a_reg_data[p.lane*DW +: DW], p.a);
        end
        checks++;
        if (out_b_reg_data[p.lane*DW +: DW] !== p.b) begin
          errors++;
          $display("FAIL %s_b: got %h want %h", nm, out_b_reg_data[p.lane*DW +: DW], p.b);
        end
        checks++;
        if (out_busy !== p.busy) begin
          errors++;
          $display("FAIL %s_busy: got %b want %b", nm, out_busy, p.busy);
        end
      end
    end
    if (out_clone_err === 1'b1) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_clone_err: got 1 want 0");
      end else begin
        string en;
        en = err_q.pop_front();
        checks++;
        if (out_clone_stall !== 1'b0 || out_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s_stall_busy: got %b%b want 00", en, out_clone_stall, out_busy);
        end
      end
    end
    if (out_busy === 1'b1) begin
      busy_run++;
    end else if (busy_run > 0) begin
      checks++;
      if (busy_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy_run: got %0d cycles want none", busy_run);
      end else begin
        int eb;
        eb = busy_q.pop_front();
        if (busy_run != eb) begin
          errors++;
          $display("FAIL busy_run: got %0d cycles want %0d", busy_run, eb);
        end
      end
      busy_run = 0;
    end
    if (out_clone_stall === 1'b1) begin
      stall_run++;
    end else if (stall_run > 0) begin
      checks++;
      if (stall_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stall_run: got %0d cycles want none", stall_run);
      end else begin
        int es;
        es = stall_q.pop_front();
        if (stall_run != es) begin
          errors++;
          $display("FAIL stall_run: got %0d cycles want %0d", stall_run, es);
        end
      end
      stall_run = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [NT-1:0] mask, input int rd, input logic [31:0] d);
    in_wb_warp        = 1'b1;
    in_write_register = 1'b1;
    in_valid          = mask;
    in_rd             = RW'(rd);
    in_write_data     = {NT{d}};
    tick();
    in_wb_warp        = 1'b0;
    in_write_register = 1'b0;
    in_valid          = '0;
  endtask

  task automatic probe(input int lane, input int s1, input int s2, input logic jal,
                       input logic f1, input logic f2, input logic [31:0] ea,
                       input logic [31:0] eb, input logic ebusy, input string nm);
    probe_t p;
    in_src1     = RW'(s1);
    in_src2     = RW'(s2);
    in_is_jal   = jal;
    in_src1_fwd = f1;
    in_src2_fwd = f2;
    p.lane = lane;
    p.a    = ea;
    p.b    = eb;
    p.busy = ebusy;
    probe_q.push_back(p);
    name_q.push_back(nm);
    rd_strobe = 1'b1;
    tick();
    rd_strobe   = 1'b0;
    in_is_jal   = 1'b0;
    in_src1_fwd = 1'b0;
    in_src2_fwd = 1'b0;
  endtask

  task automatic rd(input int lane, input int s1, input int s2, input logic [31:0] ea,
                    input logic [31:0] eb, input logic ebusy, input string nm);
    probe(lane, s1, s2, 1'b0, 1'b0, 1'b0, ea, eb, ebusy, nm);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (out_busy && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (out_busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles want idle", nm, n);
    end
  endtask

  task automatic clone_req(input int src);
    in_src1     = RW'(src);
    in_is_clone = 1'b1;
    tick();
    in_is_clone = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish want finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset             = 1'b0;
    in_wb_warp        = 1'b0;
    in_valid          = '0;
    in_write_register = 1'b0;
    in_rd             = '0;
    in_write_data     = '0;
    in_src1           = '0;
    in_src2           = '0;
    in_curr_PC        = 32'h400;
    in_is_jal         = 1'b0;
    in_src1_fwd       = 1'b0;
    in_src2_fwd       = 1'b0;
    for (int i = 0; i < NT; i++) begin
      in_src1_fwd_data[i*DW +: DW] = 32'hA000 + 32'(i);
      in_src2_fwd_data[i*DW +: DW] = 32'hB000 + 32'(i);
    end
    in_is_clone    = 1'b0;
    in_wspawn      = 1'b0;
    in_wspawn_regs = '0;
    in_wspawn_regs[0*DW +: DW] = 32'hDEAD;
    in_wspawn_regs[3*DW +: DW] = 32'h1234;
    in_wspawn_regs[7*DW +: DW] = 32'h77;

    repeat (2) tick();
    rd(0, 5, 1, 32'h0, 32'h0, 1'b0, "reset_lane0");
    rd(3, 5, 1, 32'h0, 32'h0, 1'b0, "reset_lane3");
    reset = 1'b1;
    tick();

    // Populate lanes; the x0 write must be dropped.
    wb(4'b0001, 1, 32'h2);
    wb(4'b0001, 5, 32'hA5);
    wb(4'b0001, 2, 32'h7);
    wb(4'b0001, 4, 32'h4444);
    wb(4'b0010, 5, 32'h11);
    wb(4'b1000, 5, 32'h33);
    wb(4'b0001, 0, 32'hFF);
    rd(0, 5, 1, 32'hA5, 32'h2, 1'b0, "wr_lane0");
    rd(0, 0, 2, 32'h0, 32'h7, 1'b0, "x0_zero");
    rd(1, 5, 5, 32'h11, 32'h11, 1'b0, "wr_lane1");
    rd(3, 5, 0, 32'h33, 32'h0, 1'b0, "wr_lane3");
    probe(1, 5, 5, 1'b1, 1'b1, 1'b1, 32'h400, 32'hB001, 1'b0, "jal_fwd2");
    probe(2, 5, 5, 1'b0, 1'b1, 1'b0, 32'hA002, 32'h0, 1'b0, "fwd1");

    // Illegal clone targets: lane0 x0 = 0, lane0 x2 = 7.
    err_q.push_back("err_t0");
    clone_req(0);
    err_q.push_back("err_t7");
    clone_req(2);
    rd(2, 5, 1, 32'h0, 32'h0, 1'b0, "err_nomod");

    // Clone lane0 -> lane2 with a colliding writeback on x4.
    busy_q.push_back(31);
    stall_q.push_back(32);
    clone_req(1);
    repeat (3) tick();
    wb(4'b0100, 4, 32'hBEEF);
    rd(0, 5, 4, 32'hA5, 32'h4444, 1'b1, "during_clone");
    wait_idle("clone");
    rd(2, 5, 4, 32'hA5, 32'hBEEF, 1'b0, "clone_x5_wbwin");
    rd(2, 1, 2, 32'h2, 32'h7, 1'b0, "clone_x1x2");
    rd(1, 5, 4, 32'h11, 32'h0, 1'b0, "clone_lane1_keep");
    rd(3, 5, 1, 32'h33, 32'h0, 1'b0, "clone_lane3_keep");

    // Wspawn bulk load of lane 0.
    busy_q.push_back(9);
    stall_q.push_back(10);
    in_wspawn = 1'b1;
    tick();
    in_wspawn = 1'b0;
    wait_idle("wspawn");
    rd(0, 3, 0, 32'h1234, 32'h0, 1'b0, "ws_x3_x0");
    rd(0, 7, 5, 32'h77, 32'h0, 1'b0, "ws_x7_x5");
    rd(2, 5, 3, 32'hA5, 32'h0, 1'b0, "ws_lane2_keep");

    // Clone and wspawn together: clone first, wspawn follows with no gap.
    wb(4'b0001, 1, 32'h3);
    busy_q.push_back(40);
    stall_q.push_back(41);
    in_src1     = RW'(1);
    in_is_clone = 1'b1;
    in_wspawn   = 1'b1;
    tick();
    in_is_clone = 1'b0;
    repeat (31) tick();
    in_wspawn = 1'b0;
    wait_idle("clone_ws");
    rd(3, 3, 1, 32'h1234, 32'h3, 1'b0, "sim_lane3_x3x1");
    rd(3, 5, 7, 32'h0, 32'h77, 1'b0, "sim_lane3_x5x7");
    rd(0, 1, 3, 32'h0, 32'h1234, 1'b0, "sim_ws_reload");

    // Reset in the clone cycle with k = 10.
    wb(4'b0001, 1, 32'h3);
    busy_q.push_back(9);
    stall_q.push_back(10);
    clone_req(1);
    repeat (9) tick();
    reset = 1'b0;
    rd(3, 3, 7, 32'h0, 32'h0, 1'b0, "rst_lane3");
    rd(0, 1, 7, 32'h0, 32'h0, 1'b0, "rst_lane0");
    reset = 1'b1;
    repeat (3) tick();
    rd(3, 3, 1, 32'h0, 32'h0, 1'b0, "post_rst_lane3");
    rd(0, 5, 1, 32'h0, 32'h0, 1'b0, "post_rst_lane0");
    repeat (2) tick();

    checks++;
    if (probe_q.size() != 0) begin
      errors++;
      $display("FAIL probe_leftover: got %0d want 0", probe_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL err_leftover: got %0d want 0", err_q.size());
    end
    checks++;
    if (busy_q.size() != 0) begin
      errors++;
      $display("FAIL busy_leftover: got %0d want 0", busy_q.size());
    end
    checks++;
    if (stall_q.size() != 0) begin
      errors++;
      $display("FAIL stall_leftover: got %0d want 0", stall_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
